// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and payload types for the register-file writeback path.
package regfile_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;

    typedef struct packed {
        reg_addr_t addr;
        xdata_t    data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Decode, writeback-request and register-file write signals of the writeback scheduler.
interface regfile_wb_scheduler_if #(
    parameter int unsigned NREQ = 2
);
    import regfile_ctrl_pkg::*;

    logic                 i_issue_valid;
    reg_addr_t            i_issue_rd;
    logic                 o_issue_ready;
    reg_addr_t            i_rs1_addr;
    reg_addr_t            i_rs2_addr;
    logic                 o_raw_stall;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*AW-1:0]   i_req_addr;
    logic [NREQ*XLEN-1:0] i_req_data;
    logic [NREQ-1:0]      o_req_ready;
    logic                 o_rd_wren;
    reg_addr_t            o_rd_addr;
    xdata_t               o_rd_data;

    modport slave (
        input  i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr,
        input  i_req_valid, i_req_addr, i_req_data,
        output o_issue_ready, o_raw_stall, o_req_ready,
        output o_rd_wren, o_rd_addr, o_rd_data
    );

    modport master (
        output i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr,
        output i_req_valid, i_req_addr, i_req_data,
        input  o_issue_ready, o_raw_stall, o_req_ready,
        input  o_rd_wren, o_rd_addr, o_rd_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last granted requester.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx;
    logic [IW:0]   idx;
    logic          found;

    // Rotating priority search from ptr_q; grant suppressed while in reset.
    always_comb begin
        o_grant = '0;
        gidx    = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!found && i_req[idx[IW-1:0]]) begin
                found = 1'b1;
                gidx  = idx[IW-1:0];
            end
        end
        if (found && !i_rst) begin
            o_grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_advance && found) begin
            ptr_d = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates writeback requesters onto the single register-file write port and tracks
// outstanding destination registers so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    regfile_wb_scheduler_if.slave  bus
);

    wb_req_t          req [NREQ];
    wb_req_t          sel;
    logic [NREQ-1:0]  grant;
    logic             hs;

    logic             rd_wren_q, rd_wren_d;
    reg_addr_t        rd_addr_q, rd_addr_d;
    xdata_t           rd_data_q, rd_data_d;

    logic [NREG-1:1]  pending_q, pending_d;
    logic [NREG-1:0]  pend_full;
    logic             issue_fire;

    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            req[k].addr = bus.i_req_addr[k*AW +: AW];
            req[k].data = bus.i_req_data[k*XLEN +: XLEN];
        end
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (bus.i_req_valid),
        .i_advance (hs),
        .o_grant   (grant)
    );

    assign bus.o_req_ready = grant;
    assign hs              = |(bus.i_req_valid & grant);

    // Grant is one-hot, so a priority select is equivalent to an OR mux.
    always_comb begin
        sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel = req[k];
            end
        end
    end

    // Address 0 is consumed but never written.
    always_comb begin
        rd_wren_d = hs && (sel.addr != '0);
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (hs) begin
            rd_addr_d = sel.addr;
            rd_data_d = sel.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.o_rd_wren = rd_wren_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd_data = rd_data_q;

    assign pend_full         = {pending_q, 1'b0};
    assign bus.o_issue_ready = !((bus.i_issue_rd != '0) && pend_full[bus.i_issue_rd]);
    assign bus.o_raw_stall   = ((bus.i_rs1_addr != '0) && pend_full[bus.i_rs1_addr]) ||
                               ((bus.i_rs2_addr != '0) && pend_full[bus.i_rs2_addr]);
    assign issue_fire        = bus.i_issue_valid && bus.o_issue_ready;

    // A new issue to r overrides a retiring write to the same r.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (rd_wren_q && (rd_addr_q == AW'(r))) begin
                pending_d[r] = 1'b0;
            end
            if (issue_fire && (bus.i_issue_rd == AW'(r))) begin
                pending_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule
